// File: rtl/vx_ahb_pkg.sv
// Shared AHB-Lite encodings and adapter state type for the Vortex line-to-AHB burst bridge.
package vx_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  typedef enum logic [2:0] {IDLE, ADDR, BURST, LAST, RESP, ABORT} ahb_adp_state_e;

  function automatic logic [2:0] hsize_enc(input int bytes);
    return 3'($clog2(bytes));
  endfunction

  // Fixed-length bursts only where AHB defines one; anything else is open-ended INCR.
  function automatic logic [2:0] hburst_enc(input int beats, input bit use_burst);
    if (!use_burst) return HBURST_SINGLE;
    case (beats)
      4:       return HBURST_INCR4;
      8:       return HBURST_INCR8;
      16:      return HBURST_INCR16;
      default: return HBURST_INCR;
    endcase
  endfunction

endpackage

// File: rtl/vx_ahb_beat_ctr.sv
// Modulo-BEATS beat counter; one instance tracks address phases, another data phases.
module vx_ahb_beat_ctr #(
  parameter int BEATS = 16,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          last
);

  assign last = (cnt == CW'(BEATS - 1));

  always_ff @(posedge clk) begin
    if (reset || clr) cnt <= '0;
    else if (en)      cnt <= last ? '0 : cnt + CW'(1);
  end

endmodule

// File: rtl/vx_ahb_burst_adapter.sv
// Splits one Vortex cache-line request into pipelined AHB-Lite beats and reassembles read lines.
module vx_ahb_burst_adapter
  import vx_ahb_pkg::*;
#(
  parameter int VX_DATA_WIDTH  = 512,
  parameter int VX_ADDR_WIDTH  = 32 - $clog2(VX_DATA_WIDTH/8),
  parameter int VX_TAG_WIDTH   = 8,
  parameter int AHB_DATA_WIDTH = 32,
  parameter int AHB_ADDR_WIDTH = 32,
  parameter int USE_BURST      = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        mem_req_valid,
  output logic                        mem_req_ready,
  input  logic                        mem_req_rw,
  input  logic [VX_DATA_WIDTH/8-1:0]  mem_req_byteen,
  input  logic [VX_ADDR_WIDTH-1:0]    mem_req_addr,
  input  logic [VX_DATA_WIDTH-1:0]    mem_req_data,
  input  logic [VX_TAG_WIDTH-1:0]     mem_req_tag,
  output logic                        mem_rsp_valid,
  input  logic                        mem_rsp_ready,
  output logic [VX_DATA_WIDTH-1:0]    mem_rsp_data,
  output logic [VX_TAG_WIDTH-1:0]     mem_rsp_tag,
  output logic                        mem_rsp_error,
  output logic                        bus_error,
  output logic                        HSEL,
  output logic [AHB_ADDR_WIDTH-1:0]   HADDR,
  output logic                        HWRITE,
  output logic [1:0]                  HTRANS,
  output logic [2:0]                  HBURST,
  output logic [2:0]                  HSIZE,
  output logic [AHB_DATA_WIDTH-1:0]   HWDATA,
  output logic [AHB_DATA_WIDTH/8-1:0] HWSTRB,
  input  logic [AHB_DATA_WIDTH-1:0]   HRDATA,
  input  logic                        HREADY,
  input  logic                        HRESP
);

  localparam int BEATS    = VX_DATA_WIDTH / AHB_DATA_WIDTH;
  localparam int STRB_W   = AHB_DATA_WIDTH / 8;
  localparam int LINE_OFS = $clog2(VX_DATA_WIDTH / 8);
  localparam int CW       = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [2:0] SIZE_T  = hsize_enc(STRB_W);
  localparam logic [2:0] BURST_T = hburst_enc(BEATS, USE_BURST != 0);
  localparam logic [1:0] TR_NEXT = (USE_BURST != 0) ? HTRANS_SEQ : HTRANS_NONSEQ;

  ahb_adp_state_e state, state_n;

  logic [AHB_ADDR_WIDTH-1:0]              base;
  logic                                   rw;
  logic [BEATS-1:0][AHB_DATA_WIDTH-1:0]   wdata, rbuf;
  logic [BEATS-1:0][STRB_W-1:0]           wstrb;
  logic [VX_TAG_WIDTH-1:0]                tag;
  logic                                   rsp_err;
  logic [CW-1:0]                          a_cnt, d_cnt;
  logic                                   a_last, d_last;
  logic                                   accept, data_ph, err_hit, a_en, d_en;

  assign accept  = (state == IDLE) && mem_req_valid;
  assign data_ph = (state == BURST) || (state == LAST);
  // First cycle of a two-cycle ERROR response; the counters freeze because HREADY is low.
  assign err_hit = data_ph && !HREADY && HRESP;
  assign a_en    = HREADY && ((state == ADDR) || (state == BURST));
  assign d_en    = HREADY && data_ph;

  vx_ahb_beat_ctr #(.BEATS(BEATS), .CW(CW)) u_actr (
    .clk(clk), .reset(reset), .clr(accept), .en(a_en), .cnt(a_cnt), .last(a_last)
  );

  vx_ahb_beat_ctr #(.BEATS(BEATS), .CW(CW)) u_dctr (
    .clk(clk), .reset(reset), .clr(accept), .en(d_en), .cnt(d_cnt), .last(d_last)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (mem_req_valid) state_n = ADDR;
      ADDR:  if (HREADY) begin
               if (BEATS == 1) state_n = LAST;
               else            state_n = BURST;
             end
      BURST: if (err_hit)               state_n = ABORT;
             else if (HREADY && a_last) state_n = LAST;
      LAST:  if (err_hit)               state_n = ABORT;
             else if (HREADY && d_last) state_n = rw ? IDLE : RESP;
      RESP:  if (mem_rsp_ready) state_n = IDLE;
      ABORT: if (HREADY) state_n = rw ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    HSEL          = 1'b0;
    HADDR         = '0;
    HWRITE        = 1'b0;
    HTRANS        = HTRANS_IDLE;
    HBURST        = HBURST_SINGLE;
    HSIZE         = 3'b000;
    HWDATA        = '0;
    HWSTRB        = '0;
    case (state)
      IDLE: mem_req_ready = 1'b1;
      ADDR, BURST: begin
        HSEL   = 1'b1;
        HADDR  = base + (AHB_ADDR_WIDTH'(a_cnt) << $clog2(STRB_W));
        HWRITE = rw;
        HBURST = BURST_T;
        HSIZE  = SIZE_T;
        HTRANS = (state == ADDR) ? HTRANS_NONSEQ : TR_NEXT;
      end
      LAST: HSEL = 1'b1;
      RESP: mem_rsp_valid = 1'b1;
      default: ;
    endcase
    if (data_ph && rw) begin
      HWDATA = wdata[d_cnt];
      HWSTRB = wstrb[d_cnt];
    end
    // Cancel the pending address phase as soon as the slave signals ERROR.
    if (err_hit) HTRANS = HTRANS_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base      <= '0;
      rw        <= 1'b0;
      wdata     <= '0;
      wstrb     <= '0;
      tag       <= '0;
      rbuf      <= '0;
      rsp_err   <= 1'b0;
      bus_error <= 1'b0;
    end else begin
      if (accept) begin
        base    <= AHB_ADDR_WIDTH'({mem_req_addr, {LINE_OFS{1'b0}}});
        rw      <= mem_req_rw;
        wdata   <= mem_req_data;
        wstrb   <= mem_req_byteen;
        tag     <= mem_req_tag;
        rbuf    <= '0;
        rsp_err <= 1'b0;
      end
      if (d_en && !rw) rbuf[d_cnt] <= HRDATA;
      if ((state == ABORT) && HREADY) begin
        if (rw) bus_error <= 1'b1;
        else    rsp_err   <= 1'b1;
      end
    end
  end

  assign mem_rsp_data  = rbuf;
  assign mem_rsp_tag   = tag;
  assign mem_rsp_error = rsp_err;

endmodule
